sprite_slot_ctrl: RTL and testbench
===================================

// Module: sprite_slot_ctrl
// PURPOSE
// Owns the sprite slot table (X, Y and ID per slot) that drives the per-pixel sprite mapper.
// Shares write access between NUM_REQ game-logic requesters with round-robin arbitration.
// Writes go to a shadow table. The shadow is copied to the active table once per frame, on frame_start, so the mapper never sees a half-updated table.
// Also provides a multi-cycle clear-all sweep.
// PARAMETERS
// NUM_SLOTS  16    number of sprite slots (mapper inputs PosX1..16)
// NUM_REQ    4     number of requesters
// COORD_W    10    coordinate width, matches DrawX/DrawY
// ID_W       4     sprite ID width
// EMPTY_ID   4'hF  ID marking an unused slot
// PORTS
// Clk          in   1                  system clock (50 MHz)
// Reset        in   1                  synchronous, active-high
// frame_start  in   1                  1-cycle pulse at start of vertical blank
// clear_all    in   1                  1-cycle pulse: request a sweep that empties the shadow table
// req_valid    in   NUM_REQ            per-requester write request
// req_ready    out  NUM_REQ            grant, at most one bit set
// req_slot     in   NUM_REQ*4          slot index, requester i at [4i+:4]
// req_clear    in   NUM_REQ            1 = empty the slot, 0 = write x/y/id
// req_x/req_y  in   NUM_REQ*COORD_W    position, requester i at [COORD_W*i+:COORD_W]
// req_id       in   NUM_REQ*ID_W       sprite ID
// slot_x/slot_y out NUM_SLOTS*COORD_W  active table, slot k at [COORD_W*k+:COORD_W]
// slot_id      out  NUM_SLOTS*ID_W     active table IDs
// commit_done  out  1                  1-cycle pulse: active table was just updated
// busy         out  1                  high in SWEEP or COMMIT
// err_drop     out  1                  1-cycle pulse: accepted request had slot >= NUM_SLOTS
// BEHAVIOUR
// Reset:
// - The shadow and active tables are set to x=0, y=0, id=EMPTY_ID.
// - state=RUN, rr_ptr=0, commit_pend=0; all outputs are 0 except the table outputs.
// - Reset mid-SWEEP or mid-COMMIT aborts the operation; reset values apply at the next edge.
// FSM states: RUN, SWEEP, COMMIT.
// - RUN
//   - Grant: combinational. req_ready[i]=1 for the first valid requester at or after rr_ptr, wrapping.
//   - Requesters must not make req_valid depend on req_ready.
//   - Transfer when valid&ready; at that edge the shadow[slot] is written.
//     - req_clear=1: write x=0, y=0, id=EMPTY_ID.
//     - req_clear=0: write req_x, req_y, req_id.
//   - After a grant to i, rr_ptr <= (i+1) mod NUM_REQ. With no grant, rr_ptr holds.
//   - Slot >= NUM_SLOTS: the request is still accepted (ready asserts) but no write happens. err_drop pulses the next cycle.
//   - Writes to the same slot in successive cycles: the later write wins.
//   - Transition priority in RUN:
//     1. clear_all -> SWEEP. If frame_start arrives in the same cycle, commit_pend is set.
//     2. frame_start -> COMMIT.
//   - A grant in the same cycle as frame_start/clear_all still completes and lands in the shadow.
// - SWEEP
//   - req_ready=0.
//   - Sweep counter k=0..NUM_SLOTS-1, one slot per cycle: shadow[k] <= empty.
//   - A frame_start during SWEEP sets commit_pend.
//   - clear_all during SWEEP is ignored.
//   - After slot NUM_SLOTS-1: go to COMMIT if commit_pend (and clear commit_pend), otherwise go to RUN.
// - COMMIT
//   - Exactly 1 cycle; req_ready=0.
//   - At its closing edge, active <= shadow (all slots at once) and state <= RUN.
//   - commit_done=1 for the following cycle.
//   - frame_start during COMMIT is ignored.
// Latency:
// - frame_start at cycle t (in RUN) -> COMMIT at t+1 -> new slot_* and commit_done visible at t+2.
// - Active outputs change only at the COMMIT edge or on Reset.
// - busy is registered from state: 1 in SWEEP/COMMIT, 0 in RUN.
// TESTING
// 1. Reset held 2 cycles -> every slot_id=4'hF, slot_x=slot_y=0, busy=0, req_ready=0 with no valid.
// 2. Req0 writes slot0 x=512, y=512, id=5; frame_start 3 cycles later.
//    -> slot_x[0] stays 0 until frame_start+2, then reads 512; commit_done is high exactly at frame_start+2.
// 3. req_valid=4'b1111 held 8 cycles -> grants 0,1,2,3,0,1,2,3, one-hot each cycle.
//    Then valid=4'b1010 -> grants alternate 1,3.
// 4. Req2 write (slot 7, id 3) in the same cycle as frame_start
//    -> slot_id[7]=3 at frame_start+2; req_ready=0 during the COMMIT cycle.
// 5. clear_all, then frame_start 5 cycles into the sweep
//    -> busy for 16 sweep cycles + 1 COMMIT cycle; all IDs=F after the commit; no commit before the sweep ends.
// 6. NUM_SLOTS=12, req1 slot=13
//    -> ready asserts, err_drop pulses next cycle, shadow unchanged (verified via the next commit);
//       Reset asserted mid-sweep -> reset values at the next edge.

Source files
------------

// File: rtl/sprite_slot_ctrl.sv
// Sprite slot table owner: round-robin shared writes into a shadow table,
// per-frame shadow->active commit, and a one-slot-per-cycle clear-all sweep.
module sprite_slot_ctrl #(
  parameter int unsigned     NUM_SLOTS = 16,
  parameter int unsigned     NUM_REQ   = 4,
  parameter int unsigned     COORD_W   = 10,
  parameter int unsigned     ID_W      = 4,
  parameter logic [ID_W-1:0] EMPTY_ID  = 4'hF
) (
  input  logic                           Clk,
  input  logic                           Reset,
  input  logic                           frame_start,
  input  logic                           clear_all,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*4-1:0]           req_slot,
  input  logic [NUM_REQ-1:0]             req_clear,
  input  logic [NUM_REQ*COORD_W-1:0]     req_x,
  input  logic [NUM_REQ*COORD_W-1:0]     req_y,
  input  logic [NUM_REQ*ID_W-1:0]        req_id,
  output logic [NUM_SLOTS*COORD_W-1:0]   slot_x,
  output logic [NUM_SLOTS*COORD_W-1:0]   slot_y,
  output logic [NUM_SLOTS*ID_W-1:0]      slot_id,
  output logic                           commit_done,
  output logic                           busy,
  output logic                           err_drop
);

  localparam int unsigned PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);
  localparam logic [PTR_W-1:0]  LAST_REQ  = PTR_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {RUN, SWEEP, COMMIT} state_t;

  state_t              state, state_nx;
  logic                commit_pend, pend_nx;
  logic [PTR_W-1:0]    rr_ptr;
  logic [SLOT_W-1:0]   sweep_k;

  logic [PTR_W-1:0]    cand, gnt_idx;
  logic                gnt_any;
  logic [3:0]          g_slot;
  logic                g_clear;
  logic [COORD_W-1:0]  g_x, g_y;
  logic [ID_W-1:0]     g_id;
  logic                in_range, transfer, wr_en;

  logic [COORD_W-1:0]  sh_x  [NUM_SLOTS];
  logic [COORD_W-1:0]  sh_y  [NUM_SLOTS];
  logic [ID_W-1:0]     sh_id [NUM_SLOTS];
  logic [COORD_W-1:0]  ac_x  [NUM_SLOTS];
  logic [COORD_W-1:0]  ac_y  [NUM_SLOTS];
  logic [ID_W-1:0]     ac_id [NUM_SLOTS];

  // First valid requester at or after rr_ptr, wrapping.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      cand = PTR_W'((32'(rr_ptr) + off) % NUM_REQ);
      if (!gnt_any && req_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_comb begin
    g_slot  = '0;
    g_clear = 1'b0;
    g_x     = '0;
    g_y     = '0;
    g_id    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == PTR_W'(i)) begin
        g_slot  = req_slot[i*4 +: 4];
        g_clear = req_clear[i];
        g_x     = req_x[i*COORD_W +: COORD_W];
        g_y     = req_y[i*COORD_W +: COORD_W];
        g_id    = req_id[i*ID_W +: ID_W];
      end
    end
  end

  assign in_range = 32'(g_slot) < NUM_SLOTS;
  assign transfer = (state == RUN) && gnt_any;
  assign wr_en    = transfer && in_range;

  // State register plus registered status outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= RUN;
      commit_pend <= 1'b0;
      rr_ptr      <= '0;
      sweep_k     <= '0;
      busy        <= 1'b0;
      commit_done <= 1'b0;
      err_drop    <= 1'b0;
    end else begin
      state       <= state_nx;
      commit_pend <= pend_nx;
      busy        <= (state_nx != RUN);
      commit_done <= (state == COMMIT);
      err_drop    <= transfer && !in_range;
      if (transfer)
        rr_ptr <= (gnt_idx == LAST_REQ) ? '0 : gnt_idx + 1'b1;
      sweep_k     <= (state == SWEEP) ? sweep_k + 1'b1 : '0;
    end
  end

  always_comb begin
    state_nx = state;
    pend_nx  = commit_pend;
    case (state)
      RUN: begin
        if (clear_all) begin
          state_nx = SWEEP;
          if (frame_start) pend_nx = 1'b1;
        end else if (frame_start) begin
          state_nx = COMMIT;
        end
      end
      SWEEP: begin
        if (frame_start) pend_nx = 1'b1;
        if (sweep_k == LAST_SLOT) begin
          // A frame_start landing on the final sweep cycle still gets its commit.
          if (commit_pend || frame_start) begin
            state_nx = COMMIT;
            pend_nx  = 1'b0;
          end else begin
            state_nx = RUN;
          end
        end
      end
      COMMIT:  state_nx = RUN;
      default: state_nx = RUN;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (state == RUN && gnt_any)
      req_ready = NUM_REQ'(1) << gnt_idx;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
        sh_x[k]  <= '0;
        sh_y[k]  <= '0;
        sh_id[k] <= EMPTY_ID;
        ac_x[k]  <= '0;
        ac_y[k]  <= '0;
        ac_id[k] <= EMPTY_ID;
      end
    end else begin
      if (state == COMMIT) begin
        for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
          ac_x[k]  <= sh_x[k];
          ac_y[k]  <= sh_y[k];
          ac_id[k] <= sh_id[k];
        end
      end
      if (state == SWEEP) begin
        sh_x[sweep_k]  <= '0;
        sh_y[sweep_k]  <= '0;
        sh_id[sweep_k] <= EMPTY_ID;
      end
      if (wr_en) begin
        sh_x[g_slot]  <= g_clear ? '0 : g_x;
        sh_y[g_slot]  <= g_clear ? '0 : g_y;
        sh_id[g_slot] <= g_clear ? EMPTY_ID : g_id;
      end
    end
  end

  for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_out
    assign slot_x[k*COORD_W +: COORD_W] = ac_x[k];
    assign slot_y[k*COORD_W +: COORD_W] = ac_y[k];
    assign slot_id[k*ID_W +: ID_W]      = ac_id[k];
  end

endmodule

// File: tb/tb_sprite_slot_ctrl.sv
// Bench for sprite_slot_ctrl: a 16-slot and a 12-slot instance share stimulus,
// each compared every cycle against a table-level reference model.
module tb_sprite_slot_ctrl;
  localparam int NR = 4, CW = 10, IW = 4;
  localparam int NSV[2] = '{16, 12};

  logic Clk = 1'b0;
  logic Reset, frame_start, clear_all;
  logic [NR-1:0]    req_valid, req_clear;
  logic [NR*4-1:0]  req_slot;
  logic [NR*CW-1:0] req_x, req_y;
  logic [NR*IW-1:0] req_id;

  logic [NR-1:0] ready_a, ready_b;
  logic [16*CW-1:0] sx_a, sy_a;
  logic [16*IW-1:0] sid_a;
  logic [12*CW-1:0] sx_b, sy_b;
  logic [12*IW-1:0] sid_b;
  logic done_a, done_b, busy_a, busy_b, err_a, err_b;

  int checks = 0, errors = 0;

  always #5 Clk = ~Clk;

  sprite_slot_ctrl #(.NUM_SLOTS(16), .NUM_REQ(NR), .COORD_W(CW), .ID_W(IW), .EMPTY_ID(4'hF)) dut_a (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .clear_all(clear_all),
    .req_valid(req_valid), .req_ready(ready_a), .req_slot(req_slot), .req_clear(req_clear),
    .req_x(req_x), .req_y(req_y), .req_id(req_id),
    .slot_x(sx_a), .slot_y(sy_a), .slot_id(sid_a),
    .commit_done(done_a), .busy(busy_a), .err_drop(err_a));

  sprite_slot_ctrl #(.NUM_SLOTS(12), .NUM_REQ(NR), .COORD_W(CW), .ID_W(IW), .EMPTY_ID(4'hF)) dut_b (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .clear_all(clear_all),
    .req_valid(req_valid), .req_ready(ready_b), .req_slot(req_slot), .req_clear(req_clear),
    .req_x(req_x), .req_y(req_y), .req_id(req_id),
    .slot_x(sx_b), .slot_y(sy_b), .slot_id(sid_b),
    .commit_done(done_b), .busy(busy_b), .err_drop(err_b));

  // Reference model: shadow/active tables plus "cycles of sweep left" and
  // "commit happens next edge" bookkeeping, one copy per instance.
  logic [CW-1:0] sh_x[2][16], sh_y[2][16], ac_x[2][16], ac_y[2][16];
  logic [IW-1:0] sh_id[2][16], ac_id[2][16];
  int sweep_left[2], rr[2];
  bit commit_now[2], pending[2], e_done[2], e_err[2], e_busy[2];

  function automatic int model_grant(int u);
    if (sweep_left[u] > 0 || commit_now[u]) return -1;
    for (int off = 0; off < NR; off++)
      if (req_valid[(rr[u] + off) % NR]) return (rr[u] + off) % NR;
    return -1;
  endfunction

  task automatic model_step(int u);
    int g, s, k;
    if (Reset) begin
      for (int j = 0; j < 16; j++) begin
        sh_x[u][j] = '0; sh_y[u][j] = '0; sh_id[u][j] = 4'hF;
        ac_x[u][j] = '0; ac_y[u][j] = '0; ac_id[u][j] = 4'hF;
      end
      sweep_left[u] = 0; commit_now[u] = 0; pending[u] = 0; rr[u] = 0;
      e_done[u] = 0; e_err[u] = 0; e_busy[u] = 0;
      return;
    end
    e_done[u] = 0;
    e_err[u]  = 0;
    if (commit_now[u]) begin
      for (int j = 0; j < 16; j++) begin
        ac_x[u][j] = sh_x[u][j]; ac_y[u][j] = sh_y[u][j]; ac_id[u][j] = sh_id[u][j];
      end
      e_done[u] = 1;
      commit_now[u] = 0;
    end else if (sweep_left[u] > 0) begin
      k = NSV[u] - sweep_left[u];
      sh_x[u][k] = '0; sh_y[u][k] = '0; sh_id[u][k] = 4'hF;
      sweep_left[u]--;
      if (frame_start) pending[u] = 1;
      if (sweep_left[u] == 0 && pending[u]) begin
        commit_now[u] = 1;
        pending[u] = 0;
      end
    end else begin
      g = model_grant(u);
      if (g >= 0) begin
        rr[u] = (g + 1) % NR;
        s = int'(req_slot[4*g +: 4]);
        if (s < NSV[u]) begin
          sh_x[u][s]  = req_clear[g] ? '0 : req_x[CW*g +: CW];
          sh_y[u][s]  = req_clear[g] ? '0 : req_y[CW*g +: CW];
          sh_id[u][s] = req_clear[g] ? 4'hF : req_id[IW*g +: IW];
        end else begin
          e_err[u] = 1;
        end
      end
      if (clear_all) begin
        sweep_left[u] = NSV[u];
        pending[u] = frame_start;
      end else if (frame_start) begin
        commit_now[u] = 1;
      end
    end
    e_busy[u] = (sweep_left[u] > 0) || commit_now[u];
  endtask

  // One clock: grant checked before the edge, model advanced at the edge,
  // registered outputs and the whole active table checked just after.
  task automatic tick();
    logic [NR-1:0] er, ar;
    logic [16*CW-1:0] ex, ey, axv, ayv;
    logic [16*IW-1:0] ei, aiv;
    int g;
    #1;
    for (int u = 0; u < 2; u++) begin
      if (!Reset) begin
        g  = model_grant(u);
        er = (g < 0) ? '0 : NR'(1 << g);
        ar = (u == 0) ? ready_a : ready_b;
        checks++;
        if (ar !== er) begin
          errors++;
          $display("FAIL ready u%0d t=%0t: got %b expected %b", u, $time, ar, er);
        end
      end
    end
    @(posedge Clk);
    model_step(0);
    model_step(1);
    #1;
    for (int u = 0; u < 2; u++) begin
      ex = '0; ey = '0; ei = '0;
      for (int k = 0; k < NSV[u]; k++) begin
        ex[k*CW +: CW] = ac_x[u][k];
        ey[k*CW +: CW] = ac_y[u][k];
        ei[k*IW +: IW] = ac_id[u][k];
      end
      axv = (u == 0) ? sx_a  : (16*CW)'(sx_b);
      ayv = (u == 0) ? sy_a  : (16*CW)'(sy_b);
      aiv = (u == 0) ? sid_a : (16*IW)'(sid_b);
      checks += 6;
      if (((u == 0) ? busy_a : busy_b) !== e_busy[u]) begin
        errors++; $display("FAIL busy u%0d t=%0t: got %b expected %b", u, $time, (u == 0) ? busy_a : busy_b, e_busy[u]);
      end
      if (((u == 0) ? done_a : done_b) !== e_done[u]) begin
        errors++; $display("FAIL commit_done u%0d t=%0t: got %b expected %b", u, $time, (u == 0) ? done_a : done_b, e_done[u]);
      end
      if (((u == 0) ? err_a : err_b) !== e_err[u]) begin
        errors++; $display("FAIL err_drop u%0d t=%0t: got %b expected %b", u, $time, (u == 0) ? err_a : err_b, e_err[u]);
      end
      if (axv !== ex) begin errors++; $display("FAIL slot_x u%0d t=%0t: got %h expected %h", u, $time, axv, ex); end
      if (ayv !== ey) begin errors++; $display("FAIL slot_y u%0d t=%0t: got %h expected %h", u, $time, ayv, ey); end
      if (aiv !== ei) begin errors++; $display("FAIL slot_id u%0d t=%0t: got %h expected %h", u, $time, aiv, ei); end
    end
  endtask

  task automatic set_idle();
    frame_start = 0; clear_all = 0; req_valid = '0; req_clear = '0;
    req_slot = '0; req_x = '0; req_y = '0; req_id = '0;
  endtask

  task automatic rand_fields();
    req_slot  = 16'($urandom());
    req_clear = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
    req_x     = 40'({$urandom(), $urandom()});
    req_y     = 40'({$urandom(), $urandom()});
    req_id    = 16'($urandom());
  endtask

  task automatic test_reset();
    set_idle();
    Reset = 1;
    tick(); tick();
    checks += 5;
    if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
    if (sid_a !== '1) begin errors++; $display("FAIL reset_id: got %h expected all F", sid_a); end
    if (sx_a !== '0 || sy_a !== '0) begin errors++; $display("FAIL reset_xy: got %h/%h expected 0", sx_a, sy_a); end
    if (ready_a !== '0) begin errors++; $display("FAIL reset_ready: got %b expected 0000", ready_a); end
    if (done_a !== 1'b0 || err_a !== 1'b0) begin errors++; $display("FAIL reset_pulses: got %b%b expected 00", done_a, err_a); end
    Reset = 0;
  endtask

  task automatic test_write_commit();
    set_idle();
    req_valid = 4'b0001; req_slot[3:0] = 4'd0; req_x[9:0] = 10'd512; req_y[9:0] = 10'd512; req_id[3:0] = 4'd5;
    tick();
    set_idle();
    tick(); tick();
    frame_start = 1;
    tick();
    frame_start = 0;
    checks += 2;
    if (done_a !== 1'b0) begin errors++; $display("FAIL commit_early_done: got %b expected 0", done_a); end
    if (sx_a[9:0] !== 10'd0) begin errors++; $display("FAIL commit_early_x: got %0d expected 0", sx_a[9:0]); end
    tick();
    checks += 3;
    if (done_a !== 1'b1) begin errors++; $display("FAIL commit_done_t2: got %b expected 1", done_a); end
    if (sx_a[9:0] !== 10'd512) begin errors++; $display("FAIL commit_x0: got %0d expected 512", sx_a[9:0]); end
    if (sid_a[3:0] !== 4'd5) begin errors++; $display("FAIL commit_id0: got %0d expected 5", sid_a[3:0]); end
    tick();
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_seq [12];
    exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
                4'b0010, 4'b1000, 4'b0010, 4'b1000};
    set_idle(); Reset = 1; tick(); tick(); Reset = 0;
    for (int i = 0; i < 12; i++) begin
      rand_fields();
      req_valid = (i < 8) ? 4'b1111 : 4'b1010;
      #1;
      checks++;
      if (ready_a !== exp_seq[i]) begin
        errors++; $display("FAIL rr_grant[%0d]: got %b expected %b", i, ready_a, exp_seq[i]);
      end
      tick();
    end
    set_idle(); tick();
  endtask

  task automatic test_back_to_back();
    set_idle();
    req_valid = 4'b0100; req_slot[11:8] = 4'd7; req_id[11:8] = 4'd3; req_x[29:20] = 10'd77;
    frame_start = 1;
    tick();
    frame_start = 0;
    #1;
    checks++;
    if (ready_a !== 4'b0000) begin errors++; $display("FAIL commit_cycle_ready: got %b expected 0000", ready_a); end
    tick();
    checks += 2;
    if (sid_a[7*4 +: 4] !== 4'd3) begin errors++; $display("FAIL same_cycle_id7: got %0d expected 3", sid_a[7*4 +: 4]); end
    if (done_a !== 1'b1) begin errors++; $display("FAIL same_cycle_done: got %b expected 1", done_a); end
    set_idle(); tick();
  endtask

  task automatic test_sweep();
    int nbusy = 0, first_done = -1;
    set_idle();
    clear_all = 1;
    tick();
    clear_all = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy_a) nbusy++;
      if (done_a && first_done < 0) first_done = i;
      frame_start = (i == 4);
      clear_all   = (i == 8);
      req_valid   = (i < 17) ? 4'($urandom()) : '0;
      rand_fields();
      tick();
    end
    set_idle();
    checks += 3;
    if (nbusy !== 17) begin errors++; $display("FAIL sweep_busy_cycles: got %0d expected 17", nbusy); end
    if (first_done !== 17) begin errors++; $display("FAIL sweep_commit_cycle: got %0d expected 17", first_done); end
    if (sid_a !== '1) begin errors++; $display("FAIL sweep_ids: got %h expected all F", sid_a); end
  endtask

  task automatic test_err_drop();
    set_idle(); tick();
    req_valid = 4'b0010; req_slot[7:4] = 4'd13; req_id[7:4] = 4'd9; req_x[19:10] = 10'd300;
    #1;
    checks++;
    if (ready_b !== 4'b0010) begin errors++; $display("FAIL oob_ready: got %b expected 0010", ready_b); end
    tick();
    set_idle();
    checks += 2;
    if (err_b !== 1'b1) begin errors++; $display("FAIL oob_err12: got %b expected 1", err_b); end
    if (err_a !== 1'b0) begin errors++; $display("FAIL oob_err16: got %b expected 0", err_a); end
    tick();
    checks++;
    if (err_b !== 1'b0) begin errors++; $display("FAIL oob_err_pulse: got %b expected 0", err_b); end
    frame_start = 1; tick(); frame_start = 0; tick(); tick();
  endtask

  task automatic test_reset_mid_sweep();
    set_idle();
    clear_all = 1; tick(); clear_all = 0;
    for (int i = 0; i < 6; i++) tick();
    Reset = 1;
    tick();
    checks += 2;
    if (busy_a !== 1'b0 || busy_b !== 1'b0) begin errors++; $display("FAIL midsweep_busy: got %b%b expected 00", busy_a, busy_b); end
    if (sid_a !== '1) begin errors++; $display("FAIL midsweep_ids: got %h expected all F", sid_a); end
    Reset = 0;
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      Reset       = ($urandom_range(0, 149) == 0);
      frame_start = ($urandom_range(0, 11) == 0);
      clear_all   = ($urandom_range(0, 39) == 0);
      req_valid   = 4'($urandom());
      rand_fields();
      tick();
    end
    Reset = 0; set_idle(); tick();
  endtask

  initial begin
    Reset = 1;
    set_idle();
    test_reset();
    test_write_commit();
    test_round_robin();
    test_back_to_back();
    test_sweep();
    test_err_drop();
    test_reset_mid_sweep();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
